v_store_seq: RTL and testbench

- Sequencer for vector unit-stride and strided stores (VSE8/16/32, VSSE8/16/32).
- Accepts one store command per request handshake and splits the source vector group (up to 512 bits) into 32-bit-per-bank write beats.
- Drives the four data-memory bank write ports through a grant handshake with the bank arbiter.
- Sits between vector issue/decode and the data-memory bank arbiter; reports busy, done and err.

---
 rtl/v_store_seq_pkg.sv | 59 +++++
 rtl/v_store_seq_if.sv | 50 +++++
 rtl/v_store_addr_gen.sv | 28 ++
 rtl/v_store_seq.sv | 137 +++++++++++++
 tb/tb_v_store_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/v_store_seq_pkg.sv
// Package for the vector store sequencer.
// Holds the default bus widths, the VLSU opcode constants, the sequencer
// state type and the small decode helpers shared by the sequencer files.
package v_store_seq_pkg;

    localparam int unsigned ADDR_W = 14;   // data-memory word address width
    localparam int unsigned DATA_W = 32;   // bank word width
    localparam int unsigned SRC_W  = 512;  // source vector-group width

    // VLSU opcodes (loads listed so that they can be rejected)
    localparam logic [3:0] VLSU_VLE8   = 4'h0;
    localparam logic [3:0] VLSU_VLE16  = 4'h1;
    localparam logic [3:0] VLSU_VLE32  = 4'h2;
    localparam logic [3:0] VLSU_VLSE8  = 4'h3;
    localparam logic [3:0] VLSU_VLSE16 = 4'h4;
    localparam logic [3:0] VLSU_VLSE32 = 4'h5;
    localparam logic [3:0] VLSU_VSE8   = 4'h8;
    localparam logic [3:0] VLSU_VSE16  = 4'h9;
    localparam logic [3:0] VLSU_VSE32  = 4'hA;
    localparam logic [3:0] VLSU_VSSE8  = 4'hB;
    localparam logic [3:0] VLSU_VSSE16 = 4'hC;
    localparam logic [3:0] VLSU_VSSE32 = 4'hD;

    localparam logic [2:0] VSEW_8  = 3'b000;
    localparam logic [2:0] VSEW_16 = 3'b001;
    localparam logic [2:0] VSEW_32 = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, FIN, ERR} st_seq_state_e;

    // Beats needed for one vector register; 0 marks an illegal encoding.
    function automatic logic [2:0] beats_per_reg(input logic [2:0] vsew);
        case (vsew)
            VSEW_8:  return 3'd4;
            VSEW_16: return 3'd2;
            VSEW_32: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Registers in the group; 0 marks an illegal encoding.
    function automatic logic [2:0] regs_of_lmul(input logic [2:0] lmul);
        case (lmul)
            3'b000:  return 3'd1;
            3'b001:  return 3'd2;
            3'b010:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == VLSU_VSE8)  || (op == VLSU_VSE16)  || (op == VLSU_VSE32) ||
               (op == VLSU_VSSE8) || (op == VLSU_VSSE16) || (op == VLSU_VSSE32);
    endfunction

    function automatic logic is_strided(input logic [3:0] op);
        return (op == VLSU_VSSE8) || (op == VLSU_VSSE16) || (op == VLSU_VSSE32);
    endfunction

endpackage

// File: rtl/v_store_seq_if.sv
// Bus bundle of the vector store sequencer.
// Command side: req_valid/req_ready handshake with op, vsew, lmul, addr,
// stride and data. Memory side: mem_req/mem_gnt handshake with the bank
// arbiter, per-bank we, addresses and write data. Status: busy, done, err.
// Modport master is the environment (issue logic plus arbiter); modport slave
// is the sequencer.
interface v_store_seq_if
    import v_store_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = v_store_seq_pkg::ADDR_W,
    parameter int unsigned DATA_W = v_store_seq_pkg::DATA_W,
    parameter int unsigned SRC_W  = v_store_seq_pkg::SRC_W
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [2:0]        req_vsew;
    logic [2:0]        req_lmul;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_stride;
    logic [SRC_W-1:0]  req_data;

    logic              mem_req;
    logic              mem_gnt;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr0, mem_addr1, mem_addr2, mem_addr3;
    logic [DATA_W-1:0] mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_op, req_vsew, req_lmul, req_addr, req_stride, req_data,
        output mem_gnt,
        input  req_ready, mem_req, mem_we,
        input  mem_addr0, mem_addr1, mem_addr2, mem_addr3,
        input  mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3,
        input  busy, done, err
    );

    modport slave (
        input  req_valid, req_op, req_vsew, req_lmul, req_addr, req_stride, req_data,
        input  mem_gnt,
        output req_ready, mem_req, mem_we,
        output mem_addr0, mem_addr1, mem_addr2, mem_addr3,
        output mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3,
        output busy, done, err
    );
endinterface

// File: rtl/v_store_addr_gen.sv
// Combinational address and write-enable generator for one store beat.
// Ports: base (word address), stride (words), beat (beat index), strided
// (strided op flag) in; addr[0..3] (per-bank addresses), we_mask out.
// Bank j of beat k holds element 4k+j; addresses wrap modulo 2^ADDR_W.
module v_store_addr_gen #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic [ADDR_W-1:0]      base,
    input  logic [4:0]             stride,
    input  logic [3:0]             beat,
    input  logic                   strided,
    output logic [3:0][ADDR_W-1:0] addr,
    output logic [3:0]             we_mask
);
    logic [3:0][ADDR_W-1:0] step;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            step[j] = ADDR_W'({beat, 2'(j)});
            if (strided) begin
                step[j] = ADDR_W'(stride) * step[j];
            end
            addr[j] = base + step[j];
        end
        // Zero stride hits one word four times: only the last element is written.
        we_mask = (strided && (stride == 5'd0)) ? 4'b1000 : 4'b1111;
    end
endmodule

// File: rtl/v_store_seq.sv
// Vector unit-stride / strided store sequencer.
// Ports: clk, nrst (synchronous, active-low); bus (slave modport) carrying the
// command handshake, the four bank write ports with mem_req/mem_gnt, and the
// busy/done/err status. A command is latched on accept and split into NB
// beats of four sign-extended elements each.
module v_store_seq
    import v_store_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = v_store_seq_pkg::ADDR_W,
    parameter int unsigned DATA_W = v_store_seq_pkg::DATA_W,
    parameter int unsigned SRC_W  = v_store_seq_pkg::SRC_W
) (
    input logic         clk,
    input logic         nrst,
    v_store_seq_if.slave bus
);
    st_seq_state_e     state_q, state_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        op_q;
    logic [2:0]        vsew_q, lmul_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        stride_q;
    logic [SRC_W-1:0]  data_q;

    logic                   accept, legal, last_beat, issue;
    logic [4:0]             nb;
    logic [3:0][ADDR_W-1:0] gen_addr;
    logic [3:0]             gen_we;
    logic [3:0][5:0]        elem;
    logic [3:0][DATA_W-1:0] wdata;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign legal  = is_store_op(bus.req_op) && (beats_per_reg(bus.req_vsew) != 3'd0) &&
                    (regs_of_lmul(bus.req_lmul) != 3'd0);
    assign nb        = 5'(beats_per_reg(vsew_q)) * 5'(regs_of_lmul(lmul_q));
    assign last_beat = ({1'b0, beat_q} == (nb - 5'd1));
    assign issue     = (state_q == ISSUE);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Command payload needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= bus.req_op;
            vsew_q   <= bus.req_vsew;
            lmul_q   <= bus.req_lmul;
            addr_q   <= bus.req_addr;
            stride_q <= bus.req_stride;
            data_q   <= bus.req_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        bus.req_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = legal ? ISSUE : ERR;
                    beat_d  = 4'd0;
                end
            end
            ISSUE: begin
                bus.mem_req = 1'b1;
                bus.busy    = 1'b1;
                if (bus.mem_gnt) begin
                    if (last_beat) begin
                        state_d = FIN;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            FIN: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                bus.err = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    v_store_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .base    (addr_q),
        .stride  (stride_q),
        .beat    (beat_q),
        .strided (is_strided(op_q)),
        .addr    (gen_addr),
        .we_mask (gen_we)
    );

    // Element index is masked per width so the part-select stays inside data_q.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            elem[j]  = {beat_q, 2'(j)};
            wdata[j] = '0;
            if (issue) begin
                case (vsew_q)
                    VSEW_8:  wdata[j] = DATA_W'($signed(data_q[{elem[j], 3'b000} +: 8]));
                    VSEW_16: wdata[j] = DATA_W'($signed(data_q[{elem[j][4:0], 4'b0000} +: 16]));
                    VSEW_32: wdata[j] = DATA_W'($signed(data_q[{elem[j][3:0], 5'b00000} +: 32]));
                    default: wdata[j] = '0;
                endcase
            end
        end
    end

    assign bus.mem_we     = issue ? gen_we : 4'b0000;
    assign bus.mem_addr0  = issue ? gen_addr[0] : '0;
    assign bus.mem_addr1  = issue ? gen_addr[1] : '0;
    assign bus.mem_addr2  = issue ? gen_addr[2] : '0;
    assign bus.mem_addr3  = issue ? gen_addr[3] : '0;
    assign bus.mem_wdata0 = wdata[0];
    assign bus.mem_wdata1 = wdata[1];
    assign bus.mem_wdata2 = wdata[2];
    assign bus.mem_wdata3 = wdata[3];
endmodule

// File: tb/tb_v_store_seq.sv
// Self-checking bench for v_store_seq: directed cases plus randomized
// commands and grant stalls, checked against an element-level reference model.
module tb_v_store_seq;
    import v_store_seq_pkg::*;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    v_store_seq_if #(.ADDR_W(14), .DATA_W(32), .SRC_W(512)) bus ();

    v_store_seq #(.ADDR_W(14), .DATA_W(32), .SRC_W(512)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_nb(input logic [2:0] vsew, input logic [2:0] lmul);
        int bpr, regs;
        bpr  = (vsew == 3'd0) ? 4 : (vsew == 3'd1) ? 2 : (vsew == 3'd2) ? 1 : 0;
        regs = (lmul == 3'd0) ? 1 : (lmul == 3'd1) ? 2 : (lmul == 3'd2) ? 4 : 0;
        return bpr * regs;
    endfunction

    function automatic bit model_strided(input logic [3:0] op);
        return op inside {VLSU_VSSE8, VLSU_VSSE16, VLSU_VSSE32};
    endfunction

    function automatic bit model_legal(input logic [3:0] op, input logic [2:0] vsew,
                                       input logic [2:0] lmul);
        return (op inside {VLSU_VSE8, VLSU_VSE16, VLSU_VSE32}) || model_strided(op) ?
               (model_nb(vsew, lmul) > 0) : 1'b0;
    endfunction

    // Element e of width 8<<vsew, interpreted as a signed number.
    function automatic logic [31:0] model_elem(input logic [511:0] data, input logic [2:0] vsew,
                                               input int e);
        int          ew;
        logic [511:0] sh;
        longint      v, one;
        ew  = 8 << vsew;
        sh  = data >> (e * ew);
        one = 1;
        v   = longint'(sh[31:0]) & ((one << ew) - 1);
        if (v >= (one << (ew - 1))) v = v - (one << ew);
        return 32'(v);
    endfunction

    function automatic logic [13:0] model_addr(input logic [13:0] base, input logic [4:0] stride,
                                               input bit strided, input int e);
        int a;
        a = int'(base) + (strided ? int'(stride) * e : e);
        return 14'(a % 16384);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'h0;
        bus.req_vsew   = 3'd0;
        bus.req_lmul   = 3'd0;
        bus.req_addr   = '0;
        bus.req_stride = '0;
        bus.req_data   = '0;
    endtask

    // gmode: 0 = grant always, 1 = stall stall_len cycles on stall_beat, 2 = random grant
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] vsew, input logic [2:0] lmul,
                           input logic [13:0] addr, input logic [4:0] stride,
                           input logic [511:0] data, input int gmode, input int stall_beat,
                           input int stall_len);
        int           nb, k, stalls, stall_cnt, cyc;
        bit           legal, strided, gnt, seen_done;
        logic [13:0]  obs_a [4];
        logic [31:0]  obs_d [4];
        legal   = model_legal(op, vsew, lmul);
        strided = model_strided(op);
        nb      = model_nb(vsew, lmul);
        @(negedge clk);
        check_val("ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_vsew   = vsew;
        bus.req_lmul   = lmul;
        bus.req_addr   = addr;
        bus.req_stride = stride;
        bus.req_data   = data;
        bus.mem_gnt    = 1'b0;
        @(negedge clk);
        drive_idle();
        if (!legal) begin
            check_val("err_pulse", 64'({bus.err, bus.mem_req, bus.busy, bus.req_ready}),
                      64'b1000);
            @(negedge clk);
            check_val("err_after", 64'({bus.err, bus.mem_req, bus.req_ready}), 64'b001);
            return;
        end
        k = 0; stalls = 0; stall_cnt = 0; seen_done = 1'b0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (bus.done) begin
                seen_done = 1'b1;
                check_val("beat_count", 64'(k), 64'(nb));
                check_val("done_lat", 64'(cyc), 64'(nb + 1 + stalls));
                check_val("fin_noreq", 64'({bus.mem_req, bus.mem_we, bus.busy}), 64'h01);
                break;
            end
            check_val("busy_noready", 64'({bus.busy, bus.req_ready}), 64'b10);
            if (!bus.mem_req || k >= nb) begin
                check_val($sformatf("req_beat%0d", k), 64'(bus.mem_req), 64'(k < nb));
                break;
            end
            obs_a = '{bus.mem_addr0, bus.mem_addr1, bus.mem_addr2, bus.mem_addr3};
            obs_d = '{bus.mem_wdata0, bus.mem_wdata1, bus.mem_wdata2, bus.mem_wdata3};
            for (int j = 0; j < 4; j++) begin
                check_val($sformatf("b%0d_addr%0d", k, j), 64'(obs_a[j]),
                          64'(model_addr(addr, stride, strided, 4 * k + j)));
                check_val($sformatf("b%0d_wdata%0d", k, j), 64'(obs_d[j]),
                          64'(model_elem(data, vsew, 4 * k + j)));
            end
            check_val($sformatf("b%0d_we", k), 64'(bus.mem_we),
                      (strided && stride == 5'd0) ? 64'h8 : 64'hF);
            case (gmode)
                0: gnt = 1'b1;
                1: begin
                    gnt = !(k == stall_beat && stall_cnt < stall_len);
                    if (!gnt) stall_cnt++;
                end
                default: gnt = 1'($urandom_range(0, 1));
            endcase
            if (gnt) k++; else stalls++;
            bus.mem_gnt = gnt;
            // Commands offered while busy must be ignored.
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_op    = 4'($urandom);
            bus.req_addr  = 14'($urandom);
            @(negedge clk);
        end
        if (!seen_done) check_val("done_timeout", 64'd0, 64'd1);
        drive_idle();
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        check_val("post_done", 64'({bus.done, bus.busy, bus.req_ready, bus.mem_req}), 64'b0010);
    endtask

    logic [511:0] d;
    logic [3:0]   ops [12];

    initial begin
        drive_idle();
        bus.mem_gnt = 1'b0;
        ops = '{VLSU_VLE8, VLSU_VLE16, VLSU_VLE32, VLSU_VLSE8, VLSU_VLSE16, VLSU_VLSE32,
                VLSU_VSE8, VLSU_VSE16, VLSU_VSE32, VLSU_VSSE8, VLSU_VSSE16, VLSU_VSSE32};

        repeat (3) @(negedge clk);
        check_val("rst_ctrl", 64'({bus.req_ready, bus.mem_req, bus.mem_we, bus.busy, bus.done,
                                   bus.err}), 64'b1_0_0000_0_0_0);
        check_val("rst_addr", 64'({bus.mem_addr0, bus.mem_addr1, bus.mem_addr2, bus.mem_addr3}),
                  64'd0);
        check_val("rst_wdata01", 64'({bus.mem_wdata0, bus.mem_wdata1}), 64'd0);
        check_val("rst_wdata23", 64'({bus.mem_wdata2, bus.mem_wdata3}), 64'd0);
        nrst = 1'b1;

        // VSE32, single beat
        d = '0;
        d[127:0] = 128'h44444444_33333333_22222222_11111111;
        run_cmd(VLSU_VSE32, 3'b010, 3'b000, 14'h0100, 5'd0, d, 0, 0, 0);
        // VSE8 with sign extension
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i + 'h7E);
        run_cmd(VLSU_VSE8, 3'b000, 3'b000, 14'h0010, 5'd0, d, 0, 0, 0);
        // VSSE16 with a two-cycle stall on beat 1
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        run_cmd(VLSU_VSSE16, 3'b001, 3'b001, 14'h0020, 5'd3, d, 1, 1, 2);
        // Zero stride, then address wrap
        run_cmd(VLSU_VSSE32, 3'b010, 3'b000, 14'h3FFF, 5'd0, d, 0, 0, 0);
        run_cmd(VLSU_VSE32, 3'b010, 3'b010, 14'h3FFE, 5'd0, d, 0, 0, 0);
        // Illegal commands
        run_cmd(VLSU_VSE32, 3'b011, 3'b000, 14'h0000, 5'd0, d, 0, 0, 0);
        run_cmd(VLSU_VLE32, 3'b010, 3'b000, 14'h0000, 5'd0, d, 0, 0, 0);
        run_cmd(VLSU_VSE8, 3'b000, 3'b011, 14'h0000, 5'd0, d, 0, 0, 0);

        // Randomized commands with random grants
        for (int n = 0; n < 30; n++) begin
            logic [3:0] op;
            logic [2:0] vsew, lmul;
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            op   = ($urandom_range(0, 7) == 0) ? ops[$urandom_range(0, 11)]
                                               : ops[$urandom_range(6, 11)];
            vsew = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            lmul = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_cmd(op, vsew, lmul, 14'($urandom), 5'($urandom), d, 2, 0, 0);
        end

        // Reset in the middle of a 16-beat store
        begin
            bit any_done;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = VLSU_VSE8;
            bus.req_vsew  = 3'b000;
            bus.req_lmul  = 3'b010;
            bus.req_addr  = 14'h0200;
            bus.req_data  = d;
            bus.mem_gnt   = 1'b1;
            @(negedge clk);
            drive_idle();
            repeat (5) @(negedge clk);
            check_val("rst_mid_beat5", 64'({bus.mem_req, bus.mem_addr0}), 64'({1'b1, 14'h0214}));
            nrst = 1'b0;
            @(negedge clk);
            check_val("rst_mid_out", 64'({bus.mem_req, bus.busy, bus.done, bus.req_ready}),
                      64'b0001);
            nrst = 1'b1;
            any_done = 1'b0;
            repeat (4) begin
                @(negedge clk);
                any_done = any_done | bus.done | bus.mem_req;
            end
            check_val("rst_mid_quiet", 64'(any_done), 64'd0);
            bus.mem_gnt = 1'b0;
        end
        run_cmd(VLSU_VSE32, 3'b010, 3'b000, 14'h0040, 5'd0, d, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
